// File: rtl/ibus_stream_port.sv
// ibus_stream_port: io-bus responder that bridges a 4-word register window to a
// pair of 16-bit stream FIFOs.
//   DATA   (offset 0) : write pushes TX FIFO, read pops RX FIFO
//   STATUS (offset 1) : {rx_empty, tx_full, rx_unf, tx_ovf, tx_count[5:0], rx_count[5:0]}
//   CLEAR  (offset 2) : write 1 to bit 0 / bit 1 clears tx_ovf / rx_unf
//   offset 3          : reserved
// Ports:
//   clk, rst (async, active high), rst_pipe (sync clear)
//   ibus_ren/ibus_radr -> ibus32_rdata/ibus_rhit, two cycles after the read strobe
//   ibus_wen/ibus_wadr/ibus32_wdata : single-cycle writes
//   tx_valid/tx_data/tx_ready : TX stream out (first-word fall-through)
//   rx_valid/rx_data/rx_ready : RX stream in
module ibus_stream_port #(
  parameter logic [17:0] BASE_ADR   = 18'h00100,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rst_pipe,
  input  logic        ibus_ren,
  input  logic [17:0] ibus_radr,
  output logic [15:0] ibus32_rdata,
  output logic        ibus_rhit,
  input  logic        ibus_wen,
  input  logic [17:0] ibus_wadr,
  input  logic [15:0] ibus32_wdata,
  output logic        tx_valid,
  output logic [15:0] tx_data,
  input  logic        tx_ready,
  input  logic        rx_valid,
  input  logic [15:0] rx_data,
  output logic        rx_ready
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;
  localparam int unsigned CntW  = DEPTH_LOG2 + 1;

  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef logic [CntW-1:0]       cnt_t;

  localparam cnt_t DepthCnt = cnt_t'(Depth);

  // State
  ptr_t        tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  ptr_t        rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  cnt_t        tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic        tx_ovf_q, tx_ovf_d, rx_unf_q, rx_unf_d;
  logic        s1_vld_q, s1_vld_d, out_vld_q, out_vld_d;
  logic [15:0] s1_data_q, s1_data_d, out_data_q, out_data_d;

  logic [15:0] tx_mem_q [Depth];
  logic [15:0] rx_mem_q [Depth];

  // Decode
  logic        rd_hit, wr_hit;
  logic [1:0]  rd_off, wr_off;
  logic        tx_full, tx_empty, rx_full, rx_empty;
  logic        tx_push, tx_pop, rx_push, rx_pop;
  logic        ovf_set, unf_set, clr_write;
  logic [15:0] status, rd_sel;

  assign rd_hit = ibus_ren && (ibus_radr[17:2] == BASE_ADR[17:2]);
  assign wr_hit = ibus_wen && (ibus_wadr[17:2] == BASE_ADR[17:2]);
  assign rd_off = ibus_radr[1:0];
  assign wr_off = ibus_wadr[1:0];

  assign tx_full  = (tx_cnt_q == DepthCnt);
  assign tx_empty = (tx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == DepthCnt);
  assign rx_empty = (rx_cnt_q == '0);

  // Full/empty judged on registered counts only: no same-cycle bypass either way.
  assign tx_pop    = !tx_empty && tx_ready;
  assign tx_push   = wr_hit && (wr_off == 2'd0) && !tx_full;
  assign ovf_set   = wr_hit && (wr_off == 2'd0) && tx_full;
  assign rx_push   = rx_valid && !rx_full;
  assign rx_pop    = rd_hit && (rd_off == 2'd0) && !rx_empty;
  assign unf_set   = rd_hit && (rd_off == 2'd0) && rx_empty;
  assign clr_write = wr_hit && (wr_off == 2'd2);

  assign status = {rx_empty, tx_full, rx_unf_q, tx_ovf_q, 6'(tx_cnt_q), 6'(rx_cnt_q)};

  always_comb begin
    rd_sel = '0;
    unique case (rd_off)
      2'd0:    rd_sel = rx_empty ? 16'h0000 : rx_mem_q[rx_rptr_q];
      2'd1:    rd_sel = status;
      default: rd_sel = '0;
    endcase
  end

  always_comb begin
    tx_wptr_d  = tx_push ? tx_wptr_q + ptr_t'(1) : tx_wptr_q;
    tx_rptr_d  = tx_pop  ? tx_rptr_q + ptr_t'(1) : tx_rptr_q;
    rx_wptr_d  = rx_push ? rx_wptr_q + ptr_t'(1) : rx_wptr_q;
    rx_rptr_d  = rx_pop  ? rx_rptr_q + ptr_t'(1) : rx_rptr_q;
    tx_cnt_d   = tx_cnt_q + cnt_t'(tx_push) - cnt_t'(tx_pop);
    rx_cnt_d   = rx_cnt_q + cnt_t'(rx_push) - cnt_t'(rx_pop);
    // A new event in the same cycle as a CLEAR write keeps the flag set.
    tx_ovf_d   = (tx_ovf_q && !(clr_write && ibus32_wdata[0])) || ovf_set;
    rx_unf_d   = (rx_unf_q && !(clr_write && ibus32_wdata[1])) || unf_set;
    s1_vld_d   = rd_hit;
    s1_data_d  = rd_hit ? rd_sel : 16'h0000;
    out_vld_d  = s1_vld_q;
    out_data_d = s1_data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_wptr_q  <= '0;
      tx_rptr_q  <= '0;
      rx_wptr_q  <= '0;
      rx_rptr_q  <= '0;
      tx_cnt_q   <= '0;
      rx_cnt_q   <= '0;
      tx_ovf_q   <= 1'b0;
      rx_unf_q   <= 1'b0;
      s1_vld_q   <= 1'b0;
      s1_data_q  <= '0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
    end else if (rst_pipe) begin
      tx_wptr_q  <= '0;
      tx_rptr_q  <= '0;
      rx_wptr_q  <= '0;
      rx_rptr_q  <= '0;
      tx_cnt_q   <= '0;
      rx_cnt_q   <= '0;
      tx_ovf_q   <= 1'b0;
      rx_unf_q   <= 1'b0;
      s1_vld_q   <= 1'b0;
      s1_data_q  <= '0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
    end else begin
      tx_wptr_q  <= tx_wptr_d;
      tx_rptr_q  <= tx_rptr_d;
      rx_wptr_q  <= rx_wptr_d;
      rx_rptr_q  <= rx_rptr_d;
      tx_cnt_q   <= tx_cnt_d;
      rx_cnt_q   <= rx_cnt_d;
      tx_ovf_q   <= tx_ovf_d;
      rx_unf_q   <= rx_unf_d;
      s1_vld_q   <= s1_vld_d;
      s1_data_q  <= s1_data_d;
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
    end
  end

  // FIFO storage needs no reset: content is only observed behind a non-zero count.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wptr_q] <= ibus32_wdata;
    if (rx_push) rx_mem_q[rx_wptr_q] <= rx_data;
  end

  assign ibus32_rdata = out_data_q;
  assign ibus_rhit    = out_vld_q;
  assign tx_valid     = !tx_empty;
  assign tx_data      = tx_empty ? 16'h0000 : tx_mem_q[tx_rptr_q];
  assign rx_ready     = !rx_full;

endmodule

// File: tb/tb_ibus_stream_port.sv
module tb_ibus_stream_port;

  localparam int          DEPTH  = 16;
  localparam logic [17:0] BASE   = 18'h00100;
  localparam logic [17:0] A_DATA = 18'h00100;
  localparam logic [17:0] A_STAT = 18'h00101;
  localparam logic [17:0] A_CLR  = 18'h00102;
  localparam logic [17:0] A_RSV  = 18'h00103;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rst_pipe = 1'b0;
  logic        ibus_ren = 1'b0;
  logic [17:0] ibus_radr = '0;
  logic [15:0] ibus32_rdata;
  logic        ibus_rhit;
  logic        ibus_wen = 1'b0;
  logic [17:0] ibus_wadr = '0;
  logic [15:0] ibus32_wdata = '0;
  logic        tx_valid;
  logic [15:0] tx_data;
  logic        tx_ready = 1'b0;
  logic        rx_valid = 1'b0;
  logic [15:0] rx_data = '0;
  logic        rx_ready;

  ibus_stream_port #(.BASE_ADR(BASE), .DEPTH_LOG2(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .rst_pipe     (rst_pipe),
    .ibus_ren     (ibus_ren),
    .ibus_radr    (ibus_radr),
    .ibus32_rdata (ibus32_rdata),
    .ibus_rhit    (ibus_rhit),
    .ibus_wen     (ibus_wen),
    .ibus_wadr    (ibus_wadr),
    .ibus32_wdata (ibus32_wdata),
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .tx_ready     (tx_ready),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFOs as queues, responses tagged with the cycle they are due.
  typedef struct packed {
    int          due;
    logic [15:0] data;
  } rsp_t;

  logic [15:0] m_tx[$];
  logic [15:0] m_rx[$];
  rsp_t        m_pipe[$];
  bit          m_ovf = 1'b0;
  bit          m_unf = 1'b0;
  int          cyc = 0;

  function automatic bit in_win(input logic [17:0] a);
    return (a >> 2) == (BASE >> 2);
  endfunction

  function automatic logic [15:0] m_status();
    return {m_rx.size() == 0, m_tx.size() == DEPTH, m_unf, m_ovf,
            6'(m_tx.size()), 6'(m_rx.size())};
  endfunction

  always @(posedge clk) begin : model
    logic [15:0] st, d;
    bit rx_e, rx_f, tx_f, tx_ne, ovf_set, unf_set, clr_tx, clr_rx;
    cyc++;
    if (rst || rst_pipe) begin
      m_tx.delete();
      m_rx.delete();
      m_pipe.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      st = m_status();
      rx_e = (m_rx.size() == 0);
      rx_f = (m_rx.size() == DEPTH);
      tx_f = (m_tx.size() == DEPTH);
      tx_ne = (m_tx.size() != 0);
      ovf_set = 1'b0; unf_set = 1'b0; clr_tx = 1'b0; clr_rx = 1'b0;
      if (ibus_ren && in_win(ibus_radr)) begin
        d = 16'h0000;
        case (ibus_radr[1:0])
          2'd0: if (rx_e) unf_set = 1'b1; else d = m_rx.pop_front();
          2'd1: d = st;
          default: d = 16'h0000;
        endcase
        m_pipe.push_back('{due: cyc + 1, data: d});
      end
      if (tx_ne && tx_ready) void'(m_tx.pop_front());
      if (ibus_wen && in_win(ibus_wadr)) begin
        if (ibus_wadr[1:0] == 2'd0) begin
          if (tx_f) ovf_set = 1'b1; else m_tx.push_back(ibus32_wdata);
        end else if (ibus_wadr[1:0] == 2'd2) begin
          clr_tx = ibus32_wdata[0];
          clr_rx = ibus32_wdata[1];
        end
      end
      if (rx_valid && !rx_f) m_rx.push_back(rx_data);
      m_ovf = (m_ovf && !clr_tx) || ovf_set;
      m_unf = (m_unf && !clr_rx) || unf_set;
    end
  end

  always @(negedge clk) begin : compare
    logic        eh;
    logic [15:0] ed;
    if (chk_en) begin
      while (m_pipe.size() > 0 && m_pipe[0].due < cyc) void'(m_pipe.pop_front());
      eh = 1'b0; ed = 16'h0000;
      if (m_pipe.size() > 0 && m_pipe[0].due == cyc) begin
        eh = 1'b1; ed = m_pipe[0].data;
      end
      chk("rhit", ibus_rhit, eh);
      chk("rdata", ibus32_rdata, ed);
      chk("tx_valid", tx_valid, m_tx.size() != 0);
      chk("tx_data", tx_data, (m_tx.size() != 0) ? m_tx[0] : 16'h0000);
      chk("rx_ready", rx_ready, m_rx.size() != DEPTH);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [17:0] adr, output logic [15:0] d, output logic h);
    ibus_ren = 1'b1; ibus_radr = adr;
    tick();
    ibus_ren = 1'b0;
    tick();
    d = ibus32_rdata; h = ibus_rhit;
  endtask

  task automatic wr(input logic [17:0] adr, input logic [15:0] v);
    ibus_wen = 1'b1; ibus_wadr = adr; ibus32_wdata = v;
    tick();
    ibus_wen = 1'b0;
  endtask

  function automatic logic [17:0] rand_adr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 6) return A_DATA;
    if (r == 6) return A_STAT;
    if (r == 7) return A_CLR;
    if (r == 8) return A_RSV;
    return BASE + 18'(4 + $urandom_range(0, 7));
  endfunction

  initial begin
    logic [15:0] d;
    logic        h;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;

    // Reset state
    chk("model_rst_status", m_status(), 16'h8000);
    rd(A_STAT, d, h);
    chk("rst_status", d, 16'h8000);
    chk("rst_rhit", h, 1'b1);
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_rx_ready", rx_ready, 1'b1);

    // TX fill past full, then drain
    tx_ready = 1'b0;
    for (int i = 0; i < 16; i++) wr(A_DATA, 16'h1000 + 16'(i));
    wr(A_DATA, 16'h2000);
    chk("model_tx_count", 16'(m_tx.size()), 16'd16);
    rd(A_STAT, d, h);
    chk("tx_full_status", d, 16'hD400);
    tx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("tx_seq_valid", tx_valid, 1'b1);
      chk("tx_seq", tx_data, 16'h1000 + 16'(i));
      tick();
    end
    chk("tx_drained", tx_valid, 1'b0);
    wr(A_CLR, 16'h0001);
    rd(A_STAT, d, h);
    chk("ovf_cleared", d, 16'h8000);

    // RX pop latency and underflow
    rx_valid = 1'b1; rx_data = 16'hA5A5;
    tick();
    rx_data = 16'h5A5A;
    tick();
    rx_valid = 1'b0;
    ibus_ren = 1'b1; ibus_radr = A_DATA;
    tick();
    tick();
    chk("rx_pop0", ibus32_rdata, 16'hA5A5);
    tick();
    ibus_ren = 1'b0;
    chk("rx_pop1", ibus32_rdata, 16'h5A5A);
    tick();
    chk("rx_unf_data", ibus32_rdata, 16'h0000);
    chk("rx_unf_hit", ibus_rhit, 1'b1);
    rd(A_STAT, d, h);
    chk("unf_status", d, 16'hA000);

    // CLEAR racing a new underflow: the set wins
    ibus_ren = 1'b1; ibus_radr = A_DATA;
    ibus_wen = 1'b1; ibus_wadr = A_CLR; ibus32_wdata = 16'h0002;
    tick();
    ibus_ren = 1'b0; ibus_wen = 1'b0;
    rd(A_STAT, d, h);
    chk("race_status", d, 16'hA000);
    wr(A_CLR, 16'h0002);
    wr(A_STAT, 16'hFFFF);
    rd(A_STAT, d, h);
    chk("unf_cleared", d, 16'h8000);
    rd(A_RSV, d, h);
    chk("rsv_data", d, 16'h0000);
    chk("rsv_hit", h, 1'b1);
    rd(18'h00104, d, h);
    chk("miss_hit", h, 1'b0);

    // Streaming through RX with simultaneous push and pop (wraps pointers)
    rx_valid = 1'b1; rx_data = 16'h3000;
    tick();
    for (int j = 0; j < 42; j++) begin
      if (j < 40) begin
        ibus_ren = 1'b1; ibus_radr = A_DATA; rx_data = 16'h3001 + 16'(j);
      end else begin
        ibus_ren = 1'b0; rx_valid = 1'b0;
      end
      tick();
      if (j >= 1 && j <= 40) chk("stream", ibus32_rdata, 16'h3000 + 16'(j - 1));
    end
    rd(A_STAT, d, h);
    chk("stream_status", d, 16'h0001);

    // rst_pipe with a read in flight
    ibus_ren = 1'b1; ibus_radr = A_DATA;
    tick();
    ibus_ren = 1'b0; rst_pipe = 1'b1;
    tick();
    rst_pipe = 1'b0;
    chk("rstp_rhit", ibus_rhit, 1'b0);
    chk("rstp_rdata", ibus32_rdata, 16'h0000);
    chk("rstp_rx_ready", rx_ready, 1'b1);
    chk("rstp_tx_valid", tx_valid, 1'b0);
    rd(A_STAT, d, h);
    chk("rstp_status", d, 16'h8000);

    // Randomized traffic with varying drain/fill bias
    for (int i = 0; i < 3000; i++) begin
      int ph;
      ph = i / 500;
      ibus_ren     = ($urandom_range(0, 3) < 2);
      ibus_radr    = rand_adr();
      ibus_wen     = ($urandom_range(0, 2) == 0);
      ibus_wadr    = rand_adr();
      ibus32_wdata = 16'($urandom);
      tx_ready     = ($urandom_range(0, 5) < ((ph % 2) ? 1 : 5));
      rx_valid     = ($urandom_range(0, 5) < ((ph % 3 == 0) ? 5 : 2));
      rx_data      = 16'($urandom);
      rst_pipe     = ($urandom_range(0, 299) == 0);
      tick();
    end
    ibus_ren = 1'b0; ibus_wen = 1'b0; rx_valid = 1'b0; rst_pipe = 1'b0;
    repeat (4) tick();
    chk_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
